// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder and the core's load/store unit.
package dmem_responder_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_OFF_W = 2;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned BE_W       = DATA_W / BYTE_W;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } dmem_req_t;

  // Misaligned or beyond the last word of a depth-word array.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    return (addr[WORD_OFF_W-1:0] != '0) ||
           (addr[ADDR_W-1:WORD_OFF_W] >= (ADDR_W-WORD_OFF_W)'(depth));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: synchronous clear, byte-enable write, combinational read.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [BE_W-1:0]          be_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Reset takes priority so an in-flight store can never land.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (be_i[b]) begin
          mem_q[idx_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-port memory responder: valid/ready handshake with programmable wait states,
// byte-enable stores and error signalling in front of a word-organised RAM.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dmem_req_t         req_q, req_d;
  dmem_req_t         live_req, cur_req;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              go_resp_c, mem_we_c, cur_err_c;
  logic [DATA_W-1:0] mem_rdata;

  assign live_req = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

  // With zero latency the commit happens on the accepting edge, so use the live request.
  assign cur_req   = (state_q == ST_IDLE) ? live_req : req_q;
  assign cur_err_c = addr_err(cur_req.addr, DEPTH);

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we_c),
    .idx_i   (cur_req.addr[WORD_OFF_W +: IDX_W]),
    .wdata_i (cur_req.wdata),
    .be_i    (cur_req.be),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    go_resp_c   = 1'b0;
    mem_we_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_d       = live_req;
          req_ready_d = 1'b0;
          if (LATENCY == 0) begin
            go_resp_c = 1'b1;
          end else begin
            cnt_d   = CNT_W'(LATENCY);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          go_resp_c = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase

    // Commit point: store written or load word captured, then held until handshake.
    if (go_resp_c) begin
      state_d     = ST_RESP;
      req_ready_d = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = cur_err_c;
      rsp_rdata_d = (cur_err_c || cur_req.we) ? '0 : mem_rdata;
      mem_we_c    = !cur_err_c && cur_req.we;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=0 instances against a transaction-level model.
`timescale 1ns/1ps
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int vectors    = 0;
  int miscompares = 0;
  int edge_cnt   = 0;
  bit chk_en     = 1'b0;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH(64), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Transaction model: each accepted request is due LATENCY edges after acceptance.
  logic [31:0] m_mem [2][64];
  bit          m_busy  [2];
  bit          m_valid [2];
  logic        m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_be    [2];
  int          m_due   [2];
  logic [31:0] m_rdata [2];
  logic        m_err   [2];

  task automatic model_clear(input int i);
    for (int w = 0; w < 64; w++) m_mem[i][w] = 32'h0;
    m_busy[i]  = 1'b0;
    m_valid[i] = 1'b0;
    m_rdata[i] = 32'h0;
    m_err[i]   = 1'b0;
  endtask

  task automatic model_commit(input int i);
    int unsigned idx;
    bit          err;
    idx = 32'(m_addr[i] >> 2);
    err = (m_addr[i][1:0] != 2'b00) || (idx >= 64);
    m_valid[i] = 1'b1;
    m_err[i]   = err;
    m_rdata[i] = 32'h0;
    if (!err) begin
      if (m_we[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (m_be[i][b]) m_mem[i][idx][8*b +: 8] = m_wdata[i][8*b +: 8];
        end
      end else begin
        m_rdata[i] = m_mem[i][idx];
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) model_clear(i);
    forever begin
      @(posedge clk);
      edge_cnt++;
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          model_clear(i);
        end else begin
          if (m_valid[i]) begin
            if (rsp_ready[i]) begin
              m_valid[i] = 1'b0;
              m_busy[i]  = 1'b0;
            end
          end else if (!m_busy[i] && req_valid[i]) begin
            m_busy[i]  = 1'b1;
            m_we[i]    = req_we[i];
            m_addr[i]  = req_addr[i];
            m_wdata[i] = req_wdata[i];
            m_be[i]    = req_be[i];
            m_due[i]   = edge_cnt + lat_of(i);
          end
          if (m_busy[i] && !m_valid[i] && edge_cnt == m_due[i]) model_commit(i);
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          check($sformatf("L%0d req_ready", lat_of(i)), 32'(req_ready[i]), 32'(!m_busy[i]));
          check($sformatf("L%0d rsp_valid", lat_of(i)), 32'(rsp_valid[i]), 32'(m_valid[i]));
          if (m_valid[i]) begin
            check($sformatf("L%0d rsp_rdata", lat_of(i)), rsp_rdata[i], m_rdata[i]);
            check($sformatf("L%0d rsp_err", lat_of(i)), 32'(rsp_err[i]), 32'(m_err[i]));
          end
        end
      end
    end
  end

  // One request/response with literal expectations; starts and ends on a negedge.
  task automatic txn(input int i, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int stall,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input string name, output int t_acc);
    int n;
    t_acc        = -1;
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    req_be[i]    = be;
    rsp_ready[i] = (stall == 0);
    n = 0;
    while (!req_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, " accept"}, 32'(req_ready[i]), 32'h1);
    @(negedge clk);
    t_acc        = edge_cnt;
    req_valid[i] = 1'b0;
    n = 1;
    while (!rsp_valid[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, 32'(n), 32'(lat_of(i) + 1));
    check({name, " rdata"}, rsp_rdata[i], exp_rdata);
    check({name, " err"}, 32'(rsp_err[i]), 32'(exp_err));
    repeat (stall) @(negedge clk);
    rsp_ready[i] = 1'b1;
    @(negedge clk);
    check({name, " valid drop"}, 32'(rsp_valid[i]), 32'h0);
    check({name, " ready back"}, 32'(req_ready[i]), 32'h1);
  endtask

  initial begin
    int t0, t1, t2, t3;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = 32'h0;
      req_wdata[i] = 32'h0;
      req_be[i]    = 4'h0;
      rsp_ready[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    check("reset req_ready", 32'(req_ready[0]), 32'h1);
    check("reset rsp_valid", 32'(rsp_valid[0]), 32'h0);
    check("reset rsp_rdata", rsp_rdata[0], 32'h0);
    check("reset rsp_err", 32'(rsp_err[0]), 32'h0);

    // LATENCY=2 instance
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, "st 0x10 full", t0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0, "ld 0x10", t0);
    txn(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, 32'h0, 1'b0, "st 0x10 be1", t0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, 32'hDEADBEAA, 1'b0, "ld 0x10 merged", t0);
    txn(0, 1'b1, 32'h10, 32'h12345678, 4'h0, 0, 32'h0, 1'b0, "st be0", t0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEAA, 1'b0, "ld after be0", t0);
    txn(0, 1'b0, 32'h12, 32'h0, 4'hF, 0, 32'h0, 1'b1, "ld misaligned", t0);
    txn(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b1, "st out of range", t0);
    txn(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, 32'h0, 1'b0, "ld 0x0 no alias", t0);
    txn(0, 1'b0, 32'h40000010, 32'h0, 4'hF, 0, 32'h0, 1'b1, "ld high addr", t0);
    txn(0, 1'b1, 32'h14, 32'h11223344, 4'b1010, 0, 32'h0, 1'b0, "st 0x14 be1010", t0);
    txn(0, 1'b0, 32'h14, 32'h0, 4'h0, 0, 32'h11003300, 1'b0, "ld 0x14", t0);
    txn(0, 1'b1, 32'hFC, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b0, "st last word", t0);
    txn(0, 1'b0, 32'hFC, 32'h0, 4'hF, 0, 32'hCAFEF00D, 1'b0, "ld last word", t0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 5, 32'hDEADBEAA, 1'b0, "ld stalled", t0);

    // LATENCY=0 instance: back-to-back with rsp_ready held high
    txn(1, 1'b1, 32'h8, 32'h01020304, 4'hF, 0, 32'h0, 1'b0, "L0 st 0x8", t0);
    txn(1, 1'b0, 32'h8, 32'h0, 4'hF, 0, 32'h01020304, 1'b0, "L0 ld 0x8 a", t1);
    txn(1, 1'b0, 32'h8, 32'h0, 4'hF, 0, 32'h01020304, 1'b0, "L0 ld 0x8 b", t2);
    txn(1, 1'b0, 32'h0, 32'h0, 4'hF, 0, 32'h0, 1'b0, "L0 ld 0x0", t3);
    check("L0 period a", 32'(t2 - t1), 32'h2);
    check("L0 period b", 32'(t3 - t2), 32'h2);
    txn(1, 1'b0, 32'h3, 32'h0, 4'hF, 0, 32'h0, 1'b1, "L0 ld misaligned", t0);

    // Reset while a store to 0x20 is waiting
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'h5555AAAA;
    req_be[0]    = 4'hF;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("wait state req_ready", 32'(req_ready[0]), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post-rst req_ready", 32'(req_ready[0]), 32'h1);
    check("post-rst rsp_valid", 32'(rsp_valid[0]), 32'h0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 32'h0, 1'b0, "ld 0x20 after rst", t0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data port: a word-organised data RAM behind a valid/ready request/response handshake.
- Adds programmable wait states, byte-enable writes and error signalling, so a multi-cycle core can be verified against realistic memory latency.
- Sits between the core's load/store path and the data storage, replacing the zero-latency data memory.

Parameters:
- DEPTH, 64: number of 32-bit words; power of two, 4..1024.
- LATENCY, 2: wait cycles between request acceptance and response; 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables; bit i selects wdata[8i+7:8i].
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  access was misaligned or out of range.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst, sampled on the rising edge of clk.
- Reset values:
  - state = IDLE, req_ready = 1.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - wait counter = 0, all DEPTH words cleared to 0.
- Handshake: a request is accepted only when req_valid && req_ready on a clock edge. Request inputs are ignored when req_ready = 0.
- States:
  - IDLE: req_ready = 1. On acceptance, latch we/addr/wdata/be.
    - LATENCY = 0: go to RESP.
    - Otherwise: load counter = LATENCY and go to WAIT.
  - WAIT: req_ready = 0. Counter decrements each cycle; when counter = 1, go to RESP.
  - RESP: req_ready = 0, rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready; then go to IDLE.
- Latency: a request accepted at edge T gives rsp_valid high from cycle T+1+LATENCY.
  - If rsp_ready is already high, rsp_valid is high for exactly one cycle and req_ready returns 1 the following cycle.
  - Minimum period per transaction is LATENCY+2 cycles. There is no same-cycle response/request overlap.
- Commit point: on the transition into RESP, the store is written or the load word is captured into rsp_rdata.
  - Loads therefore see all earlier committed stores.
  - A stalled response (rsp_ready low) is unaffected by anything afterwards.
- Addressing: word index = req_addr[log2(DEPTH)+1:2].
- Error conditions: req_addr[1:0] != 0, or req_addr[31:2] >= DEPTH.
  - Sets rsp_err = 1 and rsp_rdata = 0.
  - No memory write; the same latency still applies.
- Stores:
  - Only bytes with req_be[i] = 1 are written; other bytes are unchanged.
  - req_be = 0 is a legal no-op store with rsp_err = 0.
  - rsp_rdata = 0 for all stores.
- Loads: return the full 32-bit word regardless of req_be.
- Reset mid-operation (in WAIT or RESP): the transaction is aborted, nothing is committed, and the block returns to its reset values on the next cycle.
- Simultaneous rst and handshake: rst wins.

Decomposition:
- Shared package / include:
  - State encoding IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2.
  - Byte-lane width constant 8 and word-offset width constant 2, shared with the core's load/store unit.
- One sub-module, dmem_array: DEPTH x 32 storage with synchronous clear on rst, byte-enable write port and combinational read port.
- The FSM, counter and response registers stay in dmem_responder.

Test Plan:
- LATENCY = 2. Store addr 0x10, wdata 0xDEADBEEF, be 4'hF accepted at T -> rsp_valid at T+3, rsp_err 0, rsp_rdata 0. Then load 0x10 -> rsp_rdata 0xDEADBEEF.
- Byte enables: after the above, store 0x10 wdata 0x000000AA be 4'b0001 -> load 0x10 returns 0xDEADBEAA. Store with be 0 -> word unchanged, rsp_err 0.
- Errors:
  - Load 0x12 -> rsp_err 1, rsp_rdata 0.
  - Store 0x100 with DEPTH 64 -> rsp_err 1, and a later load of 0x0 returns 0 (no aliasing).
- Backpressure: hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready 0 throughout. Raise rsp_ready -> one-cycle handshake, then req_ready = 1 the next cycle.
- LATENCY = 0: back-to-back loads with rsp_ready tied high -> rsp_valid one cycle after each acceptance, one transaction every 2 cycles.
- Reset: assert rst while in WAIT of a store to 0x20 -> next cycle req_ready 1, rsp_valid 0. A later load of 0x20 returns 0.
